// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: state encoding and default sizes.
package mac_pkg;

    localparam int unsigned WIDTH_DEF      = 24;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned LEN_WIDTH_DEF  = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_LAST  = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DONE  = 3'd5
    } mac_state_e;

    function automatic logic is_active(input mac_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/mac_addr_gen.sv
// Operand address counters for memories A/B plus the remaining-read down-counter.
module mac_addr_gen
    import mac_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  rem_zero,
    output logic                  last_rd
);

    logic [ADDR_WIDTH-1:0] addr_a_r;
    logic [ADDR_WIDTH-1:0] addr_b_r;
    logic [LEN_WIDTH-1:0]  rem_r;

    // Counters: load on command accept, advance once per issued read (addresses wrap).
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_r <= {ADDR_WIDTH{1'b0}};
            addr_b_r <= {ADDR_WIDTH{1'b0}};
            rem_r    <= {LEN_WIDTH{1'b0}};
        end else if (load) begin
            addr_a_r <= base_a;
            addr_b_r <= base_b;
            rem_r    <= len;
        end else if (step) begin
            addr_a_r <= addr_a_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            addr_b_r <= addr_b_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            rem_r    <= rem_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            addr_a_r <= addr_a_r;
            addr_b_r <= addr_b_r;
            rem_r    <= rem_r;
        end
    end

    assign addr_a   = addr_a_r;
    assign addr_b   = addr_b_r;
    assign rem_zero = (rem_r == {LEN_WIDTH{1'b0}});
    assign last_rd  = (rem_r == {{(LEN_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: clears the MAC, streams N operand pairs from two
// synchronous-read memories, then returns the accumulator over valid/ready.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Start_SI,
    input  logic [LEN_WIDTH-1:0]  Len_DI,
    input  logic [ADDR_WIDTH-1:0] BaseA_DI,
    input  logic [ADDR_WIDTH-1:0] BaseB_DI,
    output logic                  Busy_SO,
    output logic                  RdEn_SO,
    output logic [ADDR_WIDTH-1:0] AddrA_DO,
    output logic [ADDR_WIDTH-1:0] AddrB_DO,
    input  logic [WIDTH-1:0]      RdDataA_DI,
    input  logic [WIDTH-1:0]      RdDataB_DI,
    output logic                  MacClr_SO,
    output logic                  MacWrEn_SO,
    output logic [WIDTH-1:0]      MacIn0_DO,
    output logic [WIDTH-1:0]      MacIn1_DO,
    input  logic [WIDTH-1:0]      MacOut_DI,
    output logic [WIDTH-1:0]      Res_DO,
    output logic                  ResValid_SO,
    input  logic                  ResReady_SI
);

    mac_state_e state_r;
    mac_state_e state_nxt_s;

    logic busy_r, rd_en_r, mac_clr_r, mac_wr_en_r, res_valid_r;
    logic busy_nxt_s, rd_en_nxt_s, mac_clr_nxt_s, res_valid_nxt_s;
    logic [WIDTH-1:0] res_r;
    logic load_s, rem_zero_s, last_rd_s;

    assign load_s = (state_r == ST_IDLE) && Start_SI;

    mac_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk      (Clk_CI),
        .rst      (Rst_RI),
        .load     (load_s),
        .step     (rd_en_r),
        .len      (Len_DI),
        .base_a   (BaseA_DI),
        .base_b   (BaseB_DI),
        .addr_a   (AddrA_DO),
        .addr_b   (AddrB_DO),
        .rem_zero (rem_zero_s),
        .last_rd  (last_rd_s)
    );

    // State register.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the remaining-read count decides how CLEAR/RUN exit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start_SI) state_nxt_s = ST_CLEAR;
                else          state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (rem_zero_s)     state_nxt_s = ST_CAPT;
                else if (last_rd_s) state_nxt_s = ST_LAST;
                else                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (last_rd_s) state_nxt_s = ST_LAST;
                else           state_nxt_s = ST_RUN;
            end
            ST_LAST: state_nxt_s = ST_CAPT;
            ST_CAPT: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (res_valid_r && ResReady_SI) state_nxt_s = ST_IDLE;
                else                            state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state so every strobe leaves a flop.
    // Entering CLEAR only happens from IDLE, so the read decision uses Len_DI.
    always_comb begin
        busy_nxt_s      = is_active(state_nxt_s);
        mac_clr_nxt_s   = (state_nxt_s == ST_CLEAR);
        res_valid_nxt_s = (state_nxt_s == ST_DONE);
        if (state_nxt_s == ST_RUN) begin
            rd_en_nxt_s = 1'b1;
        end else if (state_nxt_s == ST_CLEAR) begin
            rd_en_nxt_s = (Len_DI != {LEN_WIDTH{1'b0}});
        end else begin
            rd_en_nxt_s = 1'b0;
        end
    end

    // Output, write-enable delay and result registers.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            busy_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            mac_clr_r   <= 1'b0;
            mac_wr_en_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_r       <= {WIDTH{1'b0}};
        end else begin
            busy_r      <= busy_nxt_s;
            rd_en_r     <= rd_en_nxt_s;
            mac_clr_r   <= mac_clr_nxt_s;
            mac_wr_en_r <= rd_en_r;
            res_valid_r <= res_valid_nxt_s;
            if (state_r == ST_CAPT) res_r <= MacOut_DI;
            else                    res_r <= res_r;
        end
    end

    assign Busy_SO     = busy_r;
    assign RdEn_SO     = rd_en_r;
    assign MacClr_SO   = mac_clr_r;
    assign MacWrEn_SO  = mac_wr_en_r;
    assign MacIn0_DO   = RdDataA_DI;
    assign MacIn1_DO   = RdDataB_DI;
    assign Res_DO      = res_r;
    assign ResValid_SO = res_valid_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural MAC and two 1-cycle memories.
module tb_mac_seq_ctrl;
    localparam int W  = 24;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst, start, ready;
    logic [LW-1:0] len;
    logic [AW-1:0] base_a, base_b;
    logic          busy, rd_en, mac_clr, mac_wr, res_valid;
    logic [AW-1:0] addr_a, addr_b;
    logic [W-1:0]  rd_a, rd_b, in0, in1, acc, res;
    logic [2*W-1:0] prod;

    logic [W-1:0] mem_a [0:255];
    logic [W-1:0] mem_b [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    mac_seq_ctrl dut (
        .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .Len_DI(len),
        .BaseA_DI(base_a), .BaseB_DI(base_b), .Busy_SO(busy), .RdEn_SO(rd_en),
        .AddrA_DO(addr_a), .AddrB_DO(addr_b), .RdDataA_DI(rd_a), .RdDataB_DI(rd_b),
        .MacClr_SO(mac_clr), .MacWrEn_SO(mac_wr), .MacIn0_DO(in0), .MacIn1_DO(in1),
        .MacOut_DI(acc), .Res_DO(res), .ResValid_SO(res_valid), .ResReady_SI(ready)
    );

    always #5 clk = ~clk;

    assign prod = in0 * in1;

    always @(posedge clk) begin
        if (rst)          acc <= '0;
        else if (mac_clr) acc <= '0;
        else if (mac_wr)  acc <= acc + prod[W-1:0];
    end

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[addr_a];
            rd_b <= mem_b[addr_b];
        end
    end

    typedef struct {
        logic [LW-1:0]       len;
        logic [AW-1:0]       ba;
        logic [AW-1:0]       bb;
        logic [3:0][W-1:0]   a;
        logic [3:0][W-1:0]   b;
        int                  ready_delay;
        logic [W-1:0]        exp_res;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n, c;
        bit seen;
        logic [AW-1:0] ea, eb;
        n = int'(v.len);
        for (int k = 0; k < n && k < 4; k++) begin
            ea = v.ba + AW'(k);
            eb = v.bb + AW'(k);
            mem_a[ea] = v.a[k];
            mem_b[eb] = v.b[k];
        end
        ready  = (v.ready_delay == 0);
        len    = v.len;
        base_a = v.ba;
        base_b = v.bb;
        start  = 1'b1;
        chk("c0_idle_busy", busy, 1'b0);
        step();
        start = 1'b0;
        seen  = 1'b0;
        c     = 1;
        while (!seen && c <= n + 10) begin
            chk("busy", busy, 1'b1);
            chk("mac_clr", mac_clr, (c == 1));
            chk("rd_en", rd_en, (c >= 1 && c <= n));
            chk("mac_wr", mac_wr, (c >= 2 && c <= n + 1));
            if (rd_en) begin
                ea = v.ba + AW'(c - 1);
                eb = v.bb + AW'(c - 1);
                chk("addr_a", addr_a, ea);
                chk("addr_b", addr_b, eb);
            end
            if (res_valid) seen = 1'b1;
            else begin
                step();
                c++;
            end
        end
        chk("latency", c, (n == 0) ? 3 : n + 3);
        chk("res", res, v.exp_res);
        for (int d = 0; d < v.ready_delay; d++) begin
            step();
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_res", res, v.exp_res);
        end
        ready = 1'b1;
        step();
        chk("post_valid", res_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = W'(i + 3);
            mem_b[i] = W'(i * 5);
        end
        vecs[0] = '{len: 9'd4, ba: 8'd0,   bb: 8'd16,  a: {24'd4, 24'd3, 24'd2, 24'd1},
                    b: {24'd8, 24'd7, 24'd6, 24'd5}, ready_delay: 0, exp_res: 24'd70};
        vecs[1] = '{len: 9'd0, ba: 8'd5,   bb: 8'd5,   a: {24'd0, 24'd0, 24'd0, 24'd0},
                    b: {24'd0, 24'd0, 24'd0, 24'd0}, ready_delay: 0, exp_res: 24'd0};
        vecs[2] = '{len: 9'd3, ba: 8'd254, bb: 8'd254, a: {24'd0, 24'd4, 24'd3, 24'd2},
                    b: {24'd0, 24'd4, 24'd3, 24'd2}, ready_delay: 0, exp_res: 24'd29};
        vecs[3] = '{len: 9'd2, ba: 8'd10,  bb: 8'd20,  a: {24'd0, 24'd0, 24'd1, 24'hFFFFFF},
                    b: {24'd0, 24'd0, 24'd1, 24'd2}, ready_delay: 4, exp_res: 24'hFFFFFF};
        vecs[4] = '{len: 9'd1, ba: 8'd100, bb: 8'd200, a: {24'd0, 24'd0, 24'd0, 24'd9},
                    b: {24'd0, 24'd0, 24'd0, 24'd9}, ready_delay: 0, exp_res: 24'd81};

        rst = 1'b1; start = 1'b0; ready = 1'b1; len = '0; base_a = '0; base_b = '0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_addr_a", addr_a, 8'd0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res", res, 24'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
            step();
        end

        // Reset abort: N=8, stray Start at C3, reset during C5.
        len = 9'd8; base_a = 8'd50; base_b = 8'd60; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; len = 9'd2; base_a = 8'd0;
        step();
        start = 1'b0;
        chk("abort_c4_busy", busy, 1'b1);
        chk("abort_c4_rd", rd_en, 1'b1);
        chk("abort_c4_addr", addr_a, 8'd53);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rd", rd_en, 1'b0);
        chk("abort_addr_a", addr_a, 8'd0);
        chk("abort_addr_b", addr_b, 8'd0);
        chk("abort_clr", mac_clr, 1'b0);
        chk("abort_wr", mac_wr, 1'b0);
        chk("abort_valid", res_valid, 1'b0);
        chk("abort_res", res, 24'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_valid", res_valid, 1'b0);
            chk("abort_idle", busy, 1'b0);
        end

        run_vec(vecs[4]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
